color_sequence_player: RTL and testbench
========================================

# color_sequence_player

Parametrised successor to the fixed four-slot colour decoder. Captures a packed vector of colour codes on a start strobe and plays them one slot at a time: each code is shown as a palette colour for a programmable on-time, separated by blank gaps, with busy/done handshaking. It also holds a registered, fully decoded frame of the captured sequence for the display path. It sits between the game-logic sequence generator and the VGA pixel/colour mux.

## Interface
- SLOTS, 4, number of code slots in a sequence (≥1)
- CODE_W, 2, bits per colour code; palette has 2^CODE_W entries
- COLOR_W, 12, bits per colour (4:4:4 RGB)
- PALETTE, {12'hFF0,12'h00F,12'h0F0,12'hF00}, packed palette; entry k = PALETTE[k*COLOR_W +: COLOR_W] (0 red, 1 green, 2 blue, 3 yellow)
- BLANK, 12'h000, colour driven outside show windows
- ON_TICKS, 3, cycles each slot is shown (≥1)
- OFF_TICKS, 2, blank cycles between slots (≥0; 0 = no gap)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request playback; sampled only in IDLE
- abort  in  1  stop playback immediately, no done pulse
- seq_in  in  SLOTS*CODE_W  packed codes; slot 0 = bits [CODE_W-1:0], played first
- len  in  $clog2(SLOTS+1)  number of slots to play; values > SLOTS clamp to SLOTS
- color_out  out  COLOR_W  current colour (registered)
- color_valid  out  1  high while a slot is being shown
- slot_idx  out  $clog2(SLOTS) (min 1)  index of slot being shown / last shown
- busy  out  1  high in SHOW and GAP
- done  out  1  one-cycle pulse after the last slot completes
- frame_out  out  SLOTS*COLOR_W  registered decode of captured codes, slot k at [k*COLOR_W +: COLOR_W]

## Operation
- States: IDLE, SHOW, GAP. Registers: captured seq, captured len (clamped), slot index, tick counter sized $clog2(max(ON_TICKS,OFF_TICKS)+1).
- IDLE: color_out=BLANK, color_valid=0, busy=0. On start: capture seq_in and clamped len, load frame_out with the decode of every slot (all SLOTS decoded regardless of len), slot_idx=0, counter=0.
  - len≠0 → SHOW. len=0 → stay IDLE, done pulses next cycle.
- SHOW: color_out=PALETTE[code[slot_idx]], color_valid=1. Counter counts 0..ON_TICKS-1. At ON_TICKS-1:
  - slot_idx = len-1 → IDLE, done=1 for one cycle.
  - else if OFF_TICKS=0 → SHOW with slot_idx+1, counter=0.
  - else → GAP, counter=0.
- GAP: color_out=BLANK, color_valid=0. At OFF_TICKS-1 → SHOW, slot_idx+1, counter=0.
- start outside IDLE ignored; seq_in/len changes after capture have no effect.
- abort (any state, priority over start and over terminal transitions): next cycle IDLE, color_out=BLANK, no done; frame_out and slot_idx retained.
- done asserts only in the cycle after terminal SHOW or after a len=0 start; a start in that done cycle is accepted (state is IDLE).
- reset has priority over abort/start; mid-playback reset returns to IDLE with no done.
- Reset values: state IDLE, color_out=BLANK, color_valid=0, slot_idx=0, busy=0, done=0, frame_out=0.

## Timing
- start sampled at edge t; color_out/color_valid/busy/frame_out reflect new sequence from cycle t+1 (latency 1).
- Each slot: exactly ON_TICKS cycles with color_valid=1; gaps exactly OFF_TICKS cycles; no gap after last slot.
- Busy duration = L*ON_TICKS + (L-1)*OFF_TICKS cycles (L = clamped len ≥1); done in the cycle immediately following, busy low in that cycle.
- len=0: done high at t+1, busy never asserts.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset 2 cycles mid-SHOW → all outputs at reset values next cycle, no done.
- Basic play: seq_in=8'b11_10_01_00, len=4, defaults → red/green/blue/yellow each 3 cycles, 2-cycle BLANK gaps, busy 18 cycles, done pulse at cycle 19, frame_out=48'hFF0_00F_0F0_F00 from t+1.
- Short/clamp: len=2 → 8 busy cycles, slot_idx ends 1; len=7 with SLOTS=4 (len width 3) → plays 4 slots.
- len=0 → done at t+1, busy=0, color_valid=0 throughout; frame_out still updated.
- OFF_TICKS=0, ON_TICKS=1, seq 8'hE4, len=4 → four consecutive single-cycle colours, done at t+5.
- Abort in second GAP → IDLE next cycle, BLANK, no done; start during playback ignored; start in done cycle starts new playback at +1.

Source files
------------

// File: rtl/color_sequence_player.sv
// color_sequence_player
//
// Captures a packed vector of colour codes on a start strobe and plays them
// one slot at a time. Each code is shown as a palette colour for ON_TICKS
// cycles, with OFF_TICKS blank cycles between slots. A fully decoded frame of
// the captured sequence is also held for the display path.
//
// Handshake: start is a request that is accepted only in IDLE, on the rising
// edge where it is high. busy is high for the whole playback (SHOW and GAP).
// done is a one-cycle pulse in the cycle after the last slot ends, or in the
// cycle after a start with len = 0. abort ends playback with no done pulse.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        request playback (sampled only in IDLE)
//   abort        stop playback at once, no done pulse
//   seq_in       packed codes, slot 0 in the low bits, played first
//   len          number of slots to play, clamped to SLOTS
//   color_out    current colour (registered), BLANK outside show windows
//   color_valid  high while a slot is being shown
//   slot_idx     index of the slot being shown / last shown
//   busy         high in SHOW and GAP
//   done         one-cycle completion pulse
//   frame_out    registered decode of all captured codes
//   state_dbg    current FSM state (0 IDLE, 1 SHOW, 2 GAP)

module color_sequence_player #(
  parameter int SLOTS     = 4,
  parameter int CODE_W    = 2,
  parameter int COLOR_W   = 12,
  parameter logic [(2**CODE_W)*COLOR_W-1:0] PALETTE =
    {12'hFF0, 12'h00F, 12'h0F0, 12'hF00},
  parameter logic [COLOR_W-1:0] BLANK = 12'h000,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 2,
  localparam int LEN_W    = $clog2(SLOTS + 1),
  localparam int IDX_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SLOTS*CODE_W-1:0]  seq_in,
  input  logic [LEN_W-1:0]         len,
  output logic [COLOR_W-1:0]       color_out,
  output logic                     color_valid,
  output logic [IDX_W-1:0]         slot_idx,
  output logic                     busy,
  output logic                     done,
  output logic [SLOTS*COLOR_W-1:0] frame_out,
  output logic [1:0]               state_dbg
);

  localparam int CNT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                    state_q, state_n;
  logic [SLOTS*CODE_W-1:0]   seq_q, seq_n;
  logic [LEN_W-1:0]          len_q, len_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic [CNT_W-1:0]          cnt_q, cnt_n;
  logic [COLOR_W-1:0]        color_n;
  logic                      valid_n;
  logic                      busy_n;
  logic                      done_n;
  logic [SLOTS*COLOR_W-1:0]  frame_n;
  logic [CODE_W-1:0]         code_n;

  function automatic logic [COLOR_W-1:0] pal(input logic [CODE_W-1:0] c);
    return PALETTE[int'(c)*COLOR_W +: COLOR_W];
  endfunction

  always_comb begin
    state_n = state_q;
    seq_n   = seq_q;
    len_n   = len_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    frame_n = frame_out;

    if (abort) begin
      // slot_idx and frame are kept so the display can still show the
      // last position after an abort.
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            seq_n = seq_in;
            len_n = (len > LEN_W'(SLOTS)) ? LEN_W'(SLOTS) : len;
            idx_n = '0;
            cnt_n = '0;
            for (int k = 0; k < SLOTS; k++) begin
              frame_n[k*COLOR_W +: COLOR_W] = pal(seq_in[k*CODE_W +: CODE_W]);
            end
            if (len_n != '0) state_n = SHOW;
            else             done_n  = 1'b1;
          end
        end
        SHOW: begin
          if (int'(cnt_q) == ON_TICKS - 1) begin
            cnt_n = '0;
            if (int'(idx_q) == int'(len_q) - 1) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else if (OFF_TICKS == 0) begin
              idx_n = idx_q + IDX_W'(1);
            end else begin
              state_n = GAP;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (int'(cnt_q) == OFF_TICKS - 1) begin
            state_n = SHOW;
            idx_n   = idx_q + IDX_W'(1);
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // Outputs are computed from the next state so that the registered
    // colour lines up with the state it belongs to (one-cycle latency
    // from start).
    code_n  = seq_n[int'(idx_n)*CODE_W +: CODE_W];
    valid_n = (state_n == SHOW);
    busy_n  = (state_n != IDLE);
    color_n = valid_n ? pal(code_n) : BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      color_out   <= BLANK;
      color_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_out   <= '0;
    end else begin
      state_q     <= state_n;
      seq_q       <= seq_n;
      len_q       <= len_n;
      idx_q       <= idx_n;
      cnt_q       <= cnt_n;
      color_out   <= color_n;
      color_valid <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
      frame_out   <= frame_n;
    end
  end

  assign slot_idx  = idx_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_color_sequence_player.sv
module tb_color_sequence_player;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        start, abort;
  logic [7:0]  seq_in;
  logic [2:0]  len;
  logic [11:0] color_out;
  logic        color_valid;
  logic [1:0]  slot_idx;
  logic        busy, done;
  logic [47:0] frame_out;
  logic [1:0]  state_dbg;

  // back-to-back DUT (ON_TICKS=1, OFF_TICKS=0)
  logic        start_f, abort_f;
  logic [7:0]  seq_f;
  logic [2:0]  len_f;
  logic [11:0] color_f;
  logic        valid_f;
  logic [1:0]  slot_f;
  logic        busy_f, done_f;
  logic [47:0] frame_f;
  logic [1:0]  state_f;

  color_sequence_player dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seq_in(seq_in), .len(len), .color_out(color_out),
    .color_valid(color_valid), .slot_idx(slot_idx), .busy(busy),
    .done(done), .frame_out(frame_out), .state_dbg(state_dbg)
  );

  color_sequence_player #(.ON_TICKS(1), .OFF_TICKS(0)) dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .abort(abort_f),
    .seq_in(seq_f), .len(len_f), .color_out(color_f),
    .color_valid(valid_f), .slot_idx(slot_f), .busy(busy_f),
    .done(done_f), .frame_out(frame_f), .state_dbg(state_f)
  );

  // ---------------- scoreboard / checks ----------------
  int errors = 0;
  int checks = 0;

  logic [11:0] pal_tb [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge(s).
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a playback on the default DUT and check every cycle of it,
  // including the done pulse and the cycle after.
  task automatic play(input string tag, input logic [7:0] s, input logic [2:0] l,
                      input int n_slots, input logic [47:0] exp_frame);
    seq_in = s; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " frame"}, frame_out, exp_frame);
    for (int i = 0; i < n_slots; i++) begin
      logic [1:0] code;
      code = s[2*i +: 2];
      for (int c = 0; c < 3; c++) begin
        chk({tag, " show color"}, color_out, pal_tb[code]);
        chk({tag, " show valid"}, color_valid, 1'b1);
        chk({tag, " show busy"}, busy, 1'b1);
        chk({tag, " show done"}, done, 1'b0);
        chk({tag, " show slot"}, slot_idx, 64'(i));
        tick();
      end
      if (i < n_slots - 1) begin
        for (int c = 0; c < 2; c++) begin
          chk({tag, " gap color"}, color_out, 12'h000);
          chk({tag, " gap valid"}, color_valid, 1'b0);
          chk({tag, " gap busy"}, busy, 1'b1);
          chk({tag, " gap state"}, state_dbg, 2'd2);
          tick();
        end
      end
    end
    chk({tag, " done pulse"}, done, 1'b1);
    chk({tag, " done busy"}, busy, 1'b0);
    chk({tag, " done valid"}, color_valid, 1'b0);
    chk({tag, " done color"}, color_out, 12'h000);
    chk({tag, " last slot"}, slot_idx, 64'(n_slots - 1));
    chk({tag, " done state"}, state_dbg, 2'd0);
    tick();
    chk({tag, " done width"}, done, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; seq_in = '0; len = '0;
    start_f = 1'b0; abort_f = 1'b0; seq_f = '0; len_f = '0;
    tick(2);
    chk("rst color", color_out, 12'h000);
    chk("rst valid", color_valid, 1'b0);
    chk("rst slot", slot_idx, 2'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst frame", frame_out, 48'h0);
    chk("rst state", state_dbg, 2'd0);
    reset = 1'b0;
    tick();

    // Basic play: red, green, blue, yellow
    play("basic", 8'b11_10_01_00, 3'd4, 4, 48'hFF0_00F_0F0_F00);
    // Short: two slots (yellow, blue)
    play("len2", 8'h1B, 3'd2, 2, 48'hF00_0F0_00F_FF0);
    // Clamp: len 7 plays all four (blue, yellow, red, green)
    play("clamp", 8'h4E, 3'd7, 4, 48'h0F0_F00_FF0_00F);

    // len = 0: done next cycle, never busy, frame still updated
    seq_in = 8'h00; len = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0 done", done, 1'b1);
    chk("len0 busy", busy, 1'b0);
    chk("len0 valid", color_valid, 1'b0);
    chk("len0 frame", frame_out, 48'hF00_F00_F00_F00);
    // start in the done cycle is accepted
    seq_in = 8'h02; len = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("donecyc busy", busy, 1'b1);
    chk("donecyc valid", color_valid, 1'b1);
    chk("donecyc color", color_out, 12'h00F);
    chk("donecyc done", done, 1'b0);
    tick(2);
    chk("donecyc valid3", color_valid, 1'b1);
    tick();
    chk("donecyc done2", done, 1'b1);
    chk("donecyc busy2", busy, 1'b0);
    tick();

    // Abort in the second gap; a start during playback is ignored
    seq_in = 8'hE4; len = 3'd4; start = 1'b1;
    tick();
    seq_in = 8'hFF; len = 3'd1;
    tick();
    start = 1'b0;
    chk("ign color", color_out, 12'hF00);
    chk("ign slot", slot_idx, 2'd0);
    chk("ign frame", frame_out, 48'hFF0_00F_0F0_F00);
    tick(7);
    chk("abort pre state", state_dbg, 2'd2);
    chk("abort pre slot", slot_idx, 2'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort state", state_dbg, 2'd0);
    chk("abort busy", busy, 1'b0);
    chk("abort valid", color_valid, 1'b0);
    chk("abort color", color_out, 12'h000);
    chk("abort done", done, 1'b0);
    chk("abort slot", slot_idx, 2'd1);
    chk("abort frame", frame_out, 48'hFF0_00F_0F0_F00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort no done", done, 1'b0);
      chk("abort idle busy", busy, 1'b0);
    end

    // Reset held two cycles mid-SHOW
    seq_in = 8'hE4; len = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("prerst valid", color_valid, 1'b1);
    reset = 1'b1;
    tick(2);
    chk("midrst color", color_out, 12'h000);
    chk("midrst valid", color_valid, 1'b0);
    chk("midrst slot", slot_idx, 2'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst frame", frame_out, 48'h0);
    chk("midrst state", state_dbg, 2'd0);
    reset = 1'b0;
    tick();
    chk("postrst done", done, 1'b0);
    chk("postrst busy", busy, 1'b0);

    // ON_TICKS=1, OFF_TICKS=0: four back-to-back single-cycle colours
    seq_f = 8'hE4; len_f = 3'd4; start_f = 1'b1;
    tick();
    start_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fast color", color_f, pal_tb[i]);
      chk("fast valid", valid_f, 1'b1);
      chk("fast slot", slot_f, 64'(i));
      chk("fast done", done_f, 1'b0);
      tick();
    end
    chk("fast done pulse", done_f, 1'b1);
    chk("fast done busy", busy_f, 1'b0);
    chk("fast done valid", valid_f, 1'b0);
    chk("fast frame", frame_f, 48'hFF0_00F_0F0_F00);
    tick();
    chk("fast done width", done_f, 1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
